// File: rtl/gpio_bus_arbiter_if.sv
// Master/register-side signal bundle for the GPIO register bank arbiter.
// The slave modport is what the arbiter sees; the master modport is the requester/register side.
interface gpio_bus_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m1_req;
    logic              m0_we;
    logic              m1_we;
    logic              m0_lock;
    logic              m1_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m1_wdata;
    logic              m0_gnt;
    logic              m1_gnt;
    logic              m0_ack;
    logic              m1_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic [DATA_W-1:0] m1_rdata;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_we;
    logic [DATA_W-1:0] s_rdata;
    logic              busy;
    logic              owner;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
        output m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
        output s_addr, s_wdata, s_we, busy, owner
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
        output m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
        input  m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
        input  s_addr, s_wdata, s_we, busy, owner
    );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Purpose: round-robin (with bounded lock) arbiter/sequencer sharing gpio_reg between two masters.
// Latency: request seen in IDLE at T -> ACCESS T+1, ACK T+2+RD_LAT, IDLE T+3+RD_LAT.
// Backpressure: level req held until ack; the losing master simply waits for a later IDLE cycle.
module gpio_bus_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 4
) (
    input logic               clk,
    input logic               rst,
    gpio_bus_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam bit         HAS_WAIT  = (RD_LAT > 0);
    localparam logic [2:0] WAIT_LAST = HAS_WAIT ? 3'(RD_LAT - 1) : 3'd0;
    localparam logic [3:0] LOCK_LAST = 4'(MAX_LOCK - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;
    logic              lock_q, lock_d;
    logic [3:0]        lock_cnt_q, lock_cnt_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic own_req;
    logic own_lock;
    logic win;

    assign own_req  = owner_q ? bus.m1_req  : bus.m0_req;
    assign own_lock = owner_q ? bus.m1_lock : bus.m0_lock;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        win        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // An owner that lets go of req for even one idle cycle loses its lock.
                if (lock_q && !own_req) begin
                    lock_d     = 1'b0;
                    lock_cnt_d = 4'd0;
                end
                if (bus.m0_req || bus.m1_req) begin
                    if (lock_q && own_req)
                        win = owner_q;
                    else if (bus.m0_req && !bus.m1_req)
                        win = 1'b0;
                    else if (bus.m1_req && !bus.m0_req)
                        win = 1'b1;
                    else
                        win = ~rr_q;
                    owner_d = win;
                    addr_d  = win ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
                    we_d    = win ? bus.m1_we    : bus.m0_we;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                wait_cnt_d = 3'd0;
                state_d    = HAS_WAIT ? S_WAIT : S_ACK;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST)
                    state_d = S_ACK;
                else
                    wait_cnt_d = wait_cnt_q + 3'd1;
            end
            S_ACK: begin
                if (owner_q)
                    rdata1_d = bus.s_rdata;
                else
                    rdata0_d = bus.s_rdata;
                rr_d = owner_q;
                if (own_lock && (lock_cnt_q < LOCK_LAST)) begin
                    lock_d     = 1'b1;
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end else begin
                    lock_d     = 1'b0;
                    lock_cnt_d = 4'd0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            rr_q       <= 1'b1;
            lock_q     <= 1'b0;
            lock_cnt_q <= 4'd0;
            wait_cnt_q <= 3'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    logic active;
    logic in_ack;

    assign active = (state_q != S_IDLE);
    assign in_ack = (state_q == S_ACK);

    assign bus.m0_gnt  = active && !owner_q;
    assign bus.m1_gnt  = active &&  owner_q;
    assign bus.m0_ack  = in_ack && !owner_q;
    assign bus.m1_ack  = in_ack &&  owner_q;
    // Read data passes straight through during ACK so it is valid in the ack cycle, then holds.
    assign bus.m0_rdata = (in_ack && !owner_q) ? bus.s_rdata : rdata0_q;
    assign bus.m1_rdata = (in_ack &&  owner_q) ? bus.s_rdata : rdata1_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.s_we     = (state_q == S_ACCESS) && we_q;
    assign bus.busy     = active;
    assign bus.owner    = owner_q;
endmodule
